mux_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one output channel through the team's 2-to-1 select path (sel=0 passes requester A, sel=1 passes requester B). It locks the grant for a whole packet (valid/ready beats terminated by last), hands over to the other requester without a bubble, and enforces a maximum packet length with a sticky error flag. It sits between two packet sources and a single downstream consumer.

---
 rtl/mux_rr_arbiter_if.sv | 16 +
 rtl/mux_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// One valid/ready packet channel: a beat moves when valid and ready are both
// high at a rising clock edge. last marks the final beat of a packet. The
// source holds valid, data and last stable until the beat is accepted.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic             last;
  logic [WIDTH-1:0] data;

  // Source side drives the beat and observes ready.
  modport master (output valid, last, data, input ready);
  // Sink side observes the beat and drives ready.
  modport slave  (input valid, last, data, output ready);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one 2-to-1 select path.
// The grant is locked for a whole packet. Data is passed through
// combinationally (zero-cycle latency). Packets longer than MAX_BEATS are
// cut at MAX_BEATS beats, and the sticky err flag is raised.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  mux_rr_arbiter_if.slave  a,
  mux_rr_arbiter_if.slave  b,
  mux_rr_arbiter_if.master out,
  output logic          sel,
  output logic          busy,
  output logic [CW-1:0] beat_cnt,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            prio_q, prio_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            at_max;
  logic [WIDTH-1:0] mux_data;

  // The next accept fills the last slot that the current grant allows.
  assign at_max = (cnt_q == LAST_CNT);

  // The registered select drives the shared 2-to-1 data path.
  assign mux_data = sel_q ? b.data : a.data;
  assign out.data = mux_data;

  assign sel      = sel_q;
  assign busy     = (state_q != IDLE);
  assign beat_cnt = cnt_q;
  assign err      = err_q;

  // Next-state, arbitration and handshake steering.
  // When a packet ends and the other requester is waiting, the grant passes to
  // it at once. A forced cut (source last still low) keeps the same requester:
  // it provably has more beats, and they start a fresh packet. A natural end
  // with nobody waiting returns to IDLE.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out.valid = 1'b0;
    out.last  = 1'b0;
    a.ready   = 1'b0;
    b.ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a.valid && (!b.valid || !prio_q)) begin
          state_d = GRANT_A;
          sel_d   = 1'b0;
        end else if (b.valid) begin
          state_d = GRANT_B;
          sel_d   = 1'b1;
        end
      end
      GRANT_A: begin
        out.valid = a.valid;
        out.last  = a.last | at_max;
        a.ready   = out.ready;
        if (a.valid && out.ready) begin
          cnt_d = cnt_q + CW'(1);
          if (a.last || at_max) begin
            cnt_d  = '0;
            prio_d = 1'b1;
            if (!a.last) err_d = 1'b1;
            if (b.valid) begin
              state_d = GRANT_B;
              sel_d   = 1'b1;
            end else if (a.last) begin
              state_d = IDLE;
            end
          end
        end
      end
      GRANT_B: begin
        out.valid = b.valid;
        out.last  = b.last | at_max;
        b.ready   = out.ready;
        if (b.valid && out.ready) begin
          cnt_d = cnt_q + CW'(1);
          if (b.last || at_max) begin
            cnt_d  = '0;
            prio_d = 1'b0;
            if (!b.last) err_d = 1'b1;
            if (a.valid) begin
              state_d = GRANT_A;
              sel_d   = 1'b0;
            end else if (b.last) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset takes priority over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter with MAX_BEATS=4. Source queues feed requesters A
// and B. Every expected output beat is pushed to exp_q together with its
// stimulus, and it is popped and compared when the downstream accepts a beat.
module tb_mux_rr_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk;
  logic          rst;
  logic          sel;
  logic          busy;
  logic [CW-1:0] beat_cnt;
  logic          err;

  mux_rr_arbiter_if #(.WIDTH(W)) a_if ();
  mux_rr_arbiter_if #(.WIDTH(W)) b_if ();
  mux_rr_arbiter_if #(.WIDTH(W)) o_if ();

  mux_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a_if),
    .b        (b_if),
    .out      (o_if),
    .sel      (sel),
    .busy     (busy),
    .beat_cnt (beat_cnt),
    .err      (err)
  );

  // Source entry {valid, last, data}; valid=0 is a one-cycle bubble.
  logic [W+1:0] a_src_q[$];
  logic [W+1:0] b_src_q[$];
  logic         rdy_q[$];
  // Expected entry {contiguous, sel, last, data}.
  logic [W+2:0] exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;
  int acc_cnt  = 0;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input bit to_b, input logic v, input logic l, input logic [W-1:0] d);
    if (to_b) b_src_q.push_back({v, l, d});
    else      a_src_q.push_back({v, l, d});
  endtask

  task automatic push_exp(input logic c, input logic s, input logic l, input logic [W-1:0] d);
    exp_q.push_back({c, s, l, d});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || a_src_q.size() > 0 || b_src_q.size() > 0 ||
            rdy_q.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Driver: retire a shown beat once accepted (or a bubble after one cycle),
  // then present the next queue head just after the rising edge.
  initial begin
    logic a_shown, b_shown, a_done, b_done;
    a_shown = 1'b0; b_shown = 1'b0;
    a_if.valid = 1'b0; a_if.last = 1'b0; a_if.data = '0;
    b_if.valid = 1'b0; b_if.last = 1'b0; b_if.data = '0;
    o_if.ready = 1'b1;
    forever begin
      @(negedge clk);
      a_done = a_shown && (!a_if.valid || a_if.ready);
      b_done = b_shown && (!b_if.valid || b_if.ready);
      @(posedge clk);
      #1;
      if (a_done && a_src_q.size() > 0) void'(a_src_q.pop_front());
      if (b_done && b_src_q.size() > 0) void'(b_src_q.pop_front());
      if (a_src_q.size() > 0) begin
        {a_if.valid, a_if.last, a_if.data} = a_src_q[0];
        a_shown = 1'b1;
      end else begin
        a_if.valid = 1'b0; a_if.last = 1'b0; a_shown = 1'b0;
      end
      if (b_src_q.size() > 0) begin
        {b_if.valid, b_if.last, b_if.data} = b_src_q[0];
        b_shown = 1'b1;
      end else begin
        b_if.valid = 1'b0; b_if.last = 1'b0; b_shown = 1'b0;
      end
      o_if.ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    end
  end

  // Scoreboard: compare every accepted output beat against exp_q.
  always @(negedge clk) begin
    if (!rst && o_if.valid && o_if.ready) begin
      logic [W+2:0] e;
      acc_cnt++;
      check_eq("beat_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("beat", {sel, o_if.last, o_if.data}, e[W+1:0]);
        if (e[W+2]) check_eq("no_bubble", cyc - last_acc, 1);
      end
      last_acc = cyc;
    end
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", o_if.valid, 0);
    check_eq("rst_a_ready", a_if.ready, 0);
    check_eq("rst_b_ready", b_if.ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_last", o_if.last, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_beat_cnt", beat_cnt, 0);
    check_eq("rst_err", err, 0);

    // Both requesters start together: A first, then B with no bubble.
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      push_src(0, 1'b1, i == 2, W'(8'hA0 + i));
      push_src(1, 1'b1, i == 2, W'(8'hB0 + i));
    end
    for (int i = 0; i < 3; i++) push_exp(i != 0, 1'b0, i == 2, W'(8'hA0 + i));
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b1, i == 2, W'(8'hB0 + i));
    wait_drain("t1_drain");
    check_eq("t1_busy", busy, 0);
    check_eq("t1_sel_hold", sel, 1);

    // B alone, 2 beats, downstream ready 1,0,1.
    @(posedge clk); #2;
    push_src(1, 1'b1, 1'b0, 8'h31);
    push_src(1, 1'b1, 1'b1, 8'h32);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    push_exp(1'b0, 1'b1, 1'b0, 8'h31);
    push_exp(1'b0, 1'b1, 1'b1, 8'h32);
    @(negedge clk);
    @(negedge clk);
    check_eq("t2_idle_b_ready", b_if.ready, 0);
    check_eq("t2_idle_busy", busy, 0);
    @(negedge clk);
    check_eq("t2_b_ready_1", b_if.ready, 1);
    check_eq("t2_cnt_0", beat_cnt, 0);
    check_eq("t2_sel", sel, 1);
    @(negedge clk);
    check_eq("t2_b_ready_0", b_if.ready, 0);
    check_eq("t2_cnt_1a", beat_cnt, 1);
    @(negedge clk);
    check_eq("t2_b_ready_2", b_if.ready, 1);
    check_eq("t2_cnt_1b", beat_cnt, 1);
    check_eq("t2_out_last", o_if.last, 1);
    @(negedge clk);
    check_eq("t2_end_busy", busy, 0);
    check_eq("t2_end_cnt", beat_cnt, 0);
    wait_drain("t2_drain");

    // Single-beat packets from both requesters alternate at full rate.
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      push_src(0, 1'b1, 1'b1, W'(8'h11 + i));
      push_src(1, 1'b1, 1'b1, W'(8'h21 + i));
      push_exp(i != 0, 1'b0, 1'b1, W'(8'h11 + i));
      push_exp(1'b1, 1'b1, 1'b1, W'(8'h21 + i));
    end
    wait_drain("t3_drain");
    check_eq("t3_err", err, 0);

    // Overlength: 6 beats from A are cut after beat 4; beats 5-6 follow.
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++) begin
      push_src(0, 1'b1, i == 5, W'(8'hC0 + i));
      push_exp(i != 0, 1'b0, (i == 3) || (i == 5), W'(8'hC0 + i));
    end
    wait_drain("t4_drain");
    check_eq("t4_err", err, 1);
    repeat (3) @(negedge clk);
    check_eq("t4_err_sticky", err, 1);

    // Mid-packet stall on A while B waits: the grant stays on A.
    @(posedge clk); #2;
    push_src(0, 1'b1, 1'b0, 8'hD0);
    push_src(0, 1'b1, 1'b0, 8'hD1);
    for (int i = 0; i < 3; i++) push_src(0, 1'b0, 1'b0, 8'h00);
    push_src(0, 1'b1, 1'b0, 8'hD2);
    push_src(0, 1'b1, 1'b1, 8'hD3);
    push_exp(1'b0, 1'b0, 1'b0, 8'hD0);
    push_exp(1'b1, 1'b0, 1'b0, 8'hD1);
    push_exp(1'b0, 1'b0, 1'b0, 8'hD2);
    push_exp(1'b1, 1'b0, 1'b1, 8'hD3);
    push_exp(1'b1, 1'b1, 1'b1, 8'hE0);
    @(posedge clk); #2;
    push_src(1, 1'b1, 1'b1, 8'hE0);
    repeat (5) @(negedge clk);
    check_eq("t5_b_ready", b_if.ready, 0);
    check_eq("t5_sel", sel, 0);
    check_eq("t5_busy", busy, 1);
    check_eq("t5_out_valid", o_if.valid, 0);
    wait_drain("t5_drain");

    // Reset after 2 of 5 beats of an A packet.
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) push_src(0, 1'b1, i == 4, W'(8'hF0 + i));
    push_exp(1'b0, 1'b0, 1'b0, 8'hF0);
    push_exp(1'b1, 1'b0, 1'b0, 8'hF1);
    base = acc_cnt;
    n = 0;
    while (acc_cnt < base + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #2;
    check_eq("t6_progress", acc_cnt - base, 2);
    check_eq("t6_cnt_pre", beat_cnt, 2);
    rst = 1'b1;
    a_src_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_out_valid", o_if.valid, 0);
    check_eq("t6_sel", sel, 0);
    check_eq("t6_beat_cnt", beat_cnt, 0);
    check_eq("t6_err", err, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_exp_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
